// File: rtl/obstacle_field_if.sv
// rtl/obstacle_field_if.sv - control, pixel-position and obstacle-geometry bundle for obstacle_field
interface obstacle_field_if #(
    parameter int NUM_OBS = 3
);
    logic                   frame_tick;
    logic                   start;
    logic                   stop;
    logic                   clear;
    logic [9:0]             hcount;
    logic [8:0]             vcount;
    logic [NUM_OBS*10-1:0]  obs_left;
    logic [NUM_OBS*10-1:0]  obs_right;
    logic [NUM_OBS*9-1:0]   gap_top;
    logic [NUM_OBS*9-1:0]   gap_bot;
    logic [NUM_OBS-1:0]     obs_active;
    logic                   pixel_on;
    logic                   score_pulse;
    logic [1:0]             state;

    modport master (
        output frame_tick, start, stop, clear, hcount, vcount,
        input  obs_left, obs_right, gap_top, gap_bot, obs_active,
               pixel_on, score_pulse, state
    );

    modport slave (
        input  frame_tick, start, stop, clear, hcount, vcount,
        output obs_left, obs_right, gap_top, gap_bot, obs_active,
               pixel_on, score_pulse, state
    );
endinterface

// File: rtl/obstacle_field.sv
// rtl/obstacle_field.sv - scrolling multi-channel obstacle field with LFSR gaps; OBSTACLE_SPEED_RAMP_EN adds speed ramp
module obstacle_field #(
    parameter int NUM_OBS       = 3,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int OBS_WIDTH     = 40,
    parameter int GAP_HEIGHT    = 120,
    parameter int GAP_MIN       = 40,
    parameter int SPACING       = 240,
    parameter int SPEED         = 2,
    parameter int BIRD_X        = 160,
`ifdef OBSTACLE_SPEED_RAMP_EN
    parameter int RAMP_PASSES   = 5,
    parameter int MAX_SPEED     = 6,
`endif
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset_n,
    obstacle_field_if.slave    bus
);

    localparam logic [1:0] ST_HOLD   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_FROZEN = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d, lfsr_next;
    logic [10:0] pos_q [NUM_OBS];
    logic [10:0] pos_d [NUM_OBS];
    logic [8:0]  gap_top_q [NUM_OBS];
    logic [8:0]  gap_top_d [NUM_OBS];
    logic        pixel_on_q, pixel_on_d;
    logic        score_q, score_d;
    logic        motion;
    logic [10:0] spd;

    logic [NUM_OBS*10-1:0] obs_left_w, obs_right_w;
    logic [NUM_OBS*9-1:0]  gap_top_w, gap_bot_w;
    logic [NUM_OBS-1:0]    obs_active_w;

    assign motion    = (state_q == ST_RUN) && bus.frame_tick && !bus.stop && !bus.clear;
    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    // Geometry is clamped to the visible area; channels waiting off-screen collapse to an empty span.
    always_comb begin
        obs_left_w   = '0;
        obs_right_w  = '0;
        gap_top_w    = '0;
        gap_bot_w    = '0;
        obs_active_w = '0;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (pos_q[i] >= 11'(OBS_WIDTH)) begin
                if ((pos_q[i] - 11'(OBS_WIDTH)) > 11'(SCREEN_WIDTH))
                    obs_left_w[i*10 +: 10] = 10'(SCREEN_WIDTH);
                else
                    obs_left_w[i*10 +: 10] = 10'(pos_q[i] - 11'(OBS_WIDTH));
            end
            obs_right_w[i*10 +: 10] = (pos_q[i] > 11'(SCREEN_WIDTH)) ? 10'(SCREEN_WIDTH)
                                                                     : pos_q[i][9:0];
            gap_top_w[i*9 +: 9]     = gap_top_q[i];
            gap_bot_w[i*9 +: 9]     = gap_top_q[i] + 9'(GAP_HEIGHT);
            obs_active_w[i]         = (pos_q[i] < 11'(SCREEN_WIDTH + OBS_WIDTH)) && (pos_q[i] != 11'd0);
        end
    end

    always_comb begin
        pixel_on_d = 1'b0;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (obs_active_w[i]
                && (bus.hcount >= obs_left_w[i*10 +: 10])
                && (bus.hcount <  obs_right_w[i*10 +: 10])
                && (bus.vcount <  9'(SCREEN_HEIGHT))
                && ((bus.vcount < gap_top_w[i*9 +: 9]) || (bus.vcount >= gap_bot_w[i*9 +: 9])))
                pixel_on_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        score_d = 1'b0;
        for (int i = 0; i < NUM_OBS; i++) begin
            pos_d[i]     = pos_q[i];
            gap_top_d[i] = gap_top_q[i];
        end

        if (motion) begin
            lfsr_d = lfsr_next;
            for (int i = 0; i < NUM_OBS; i++) begin
                if (pos_q[i] > spd) begin
                    pos_d[i] = pos_q[i] - spd;
                    if ((pos_q[i] > 11'(BIRD_X)) && ((pos_q[i] - spd) <= 11'(BIRD_X)))
                        score_d = 1'b1;
                end else begin
                    // Respawn one full field-length behind; keeps the channel spacing intact.
                    pos_d[i]     = pos_q[i] + 11'(NUM_OBS * SPACING) - spd;
                    gap_top_d[i] = 9'(GAP_MIN) + {1'b0, lfsr_next[7:0]};
                end
            end
        end

        if (bus.clear) begin
            state_d = ST_HOLD;
            for (int i = 0; i < NUM_OBS; i++) begin
                pos_d[i]     = 11'(SCREEN_WIDTH + OBS_WIDTH + i * SPACING);
                gap_top_d[i] = 9'(GAP_MIN);
            end
        end else begin
            case (state_q)
                ST_HOLD:   if (bus.start) state_d = ST_RUN;
                ST_RUN:    if (bus.stop)  state_d = ST_FROZEN;
                ST_FROZEN: state_d = ST_FROZEN;
                default:   state_d = ST_HOLD;
            endcase
        end
    end

`ifdef OBSTACLE_SPEED_RAMP_EN
    logic [3:0] spd_q, spd_d;
    logic [7:0] pass_q, pass_d;

    assign spd = 11'(spd_q);

    always_comb begin
        spd_d  = spd_q;
        pass_d = pass_q;
        if (bus.clear) begin
            spd_d  = 4'(SPEED);
            pass_d = 8'd0;
        end else if (score_d) begin
            if (pass_q == 8'(RAMP_PASSES - 1)) begin
                pass_d = 8'd0;
                if (spd_q < 4'(MAX_SPEED))
                    spd_d = spd_q + 4'd1;
            end else begin
                pass_d = pass_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            spd_q  <= 4'(SPEED);
            pass_q <= 8'd0;
        end else begin
            spd_q  <= spd_d;
            pass_q <= pass_d;
        end
    end
`else
    assign spd = 11'(SPEED);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_HOLD;
            lfsr_q     <= LFSR_SEED;
            pixel_on_q <= 1'b0;
            score_q    <= 1'b0;
            for (int i = 0; i < NUM_OBS; i++) begin
                pos_q[i]     <= 11'(SCREEN_WIDTH + OBS_WIDTH + i * SPACING);
                gap_top_q[i] <= 9'(GAP_MIN);
            end
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            pixel_on_q <= pixel_on_d;
            score_q    <= score_d;
            for (int i = 0; i < NUM_OBS; i++) begin
                pos_q[i]     <= pos_d[i];
                gap_top_q[i] <= gap_top_d[i];
            end
        end
    end

    assign bus.obs_left    = obs_left_w;
    assign bus.obs_right   = obs_right_w;
    assign bus.gap_top     = gap_top_w;
    assign bus.gap_bot     = gap_bot_w;
    assign bus.obs_active  = obs_active_w;
    assign bus.pixel_on    = pixel_on_q;
    assign bus.score_pulse = score_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_obstacle_field.sv
// tb/tb_obstacle_field.sv - vector table plus scroll/score/respawn sequences for obstacle_field
module tb_obstacle_field;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    obstacle_field_if #(.NUM_OBS(3)) bus();

    obstacle_field dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic       rst_n;
        logic       st;
        logic       sp;
        logic       cl;
        logic       tk;
        int         reps;
        logic [9:0] hc;
        logic [8:0] vc;
        logic [1:0] e_state;
        logic [9:0] e_left0;
        logic [9:0] e_right0;
        logic [2:0] e_act;
        logic       chk_pix;
        logic       e_pix;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input int id, input string what, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL v%0d %s: got %0d expected %0d", id, what, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        logic [15:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 16'hB400;
        return y;
    endfunction

    task automatic drive(input logic r, input logic s, input logic p, input logic c, input logic t,
                         input logic [9:0] h, input logic [8:0] v);
        reset_n        = r;
        bus.start      = s;
        bus.stop       = p;
        bus.clear      = c;
        bus.frame_tick = t;
        bus.hcount     = h;
        bus.vcount     = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int          stray;
    int          seen;
    logic [15:0] lfsr_m;
    logic [8:0]  exp_gt;

    initial begin
        //            rst st sp cl tk reps  hc    vc  state left0 right0 act  chk pix
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 2, 10'd0,  9'd0,  2'd0, 10'd640,10'd640,3'b000,1'b1,1'b0};
        vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1, 10'd0,  9'd0,  2'd1, 10'd640,10'd640,3'b000,1'b0,1'b0};
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1, 10'd0,  9'd0,  2'd1, 10'd638,10'd640,3'b001,1'b0,1'b0};
        vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,99, 10'd0,  9'd0,  2'd1, 10'd440,10'd480,3'b001,1'b0,1'b0};
        vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1, 10'd450,9'd10, 2'd1, 10'd440,10'd480,3'b001,1'b1,1'b1};
        vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1, 10'd450,9'd100,2'd1, 10'd440,10'd480,3'b001,1'b1,1'b0};
        vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1, 10'd439,9'd10, 2'd1, 10'd440,10'd480,3'b001,1'b1,1'b0};
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1, 10'd479,9'd479,2'd1, 10'd440,10'd480,3'b001,1'b1,1'b1};
        vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1, 10'd480,9'd479,2'd1, 10'd440,10'd480,3'b001,1'b1,1'b0};
        vecs[9]  = '{1'b1,1'b0,1'b1,1'b0,1'b1, 1, 10'd0,  9'd0,  2'd2, 10'd440,10'd480,3'b001,1'b0,1'b0};
        vecs[10] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 5, 10'd0,  9'd0,  2'd2, 10'd440,10'd480,3'b001,1'b0,1'b0};
        vecs[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1, 10'd450,9'd10, 2'd2, 10'd440,10'd480,3'b001,1'b1,1'b1};
        vecs[12] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1, 10'd0,  9'd0,  2'd2, 10'd440,10'd480,3'b001,1'b0,1'b0};
        vecs[13] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 1, 10'd0,  9'd0,  2'd0, 10'd640,10'd640,3'b000,1'b0,1'b0};
        vecs[14] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1, 10'd0,  9'd0,  2'd0, 10'd640,10'd640,3'b000,1'b0,1'b0};
        vecs[15] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 3, 10'd0,  9'd0,  2'd0, 10'd640,10'd640,3'b000,1'b0,1'b0};
        vecs[16] = '{1'b1,1'b1,1'b1,1'b1,1'b1, 1, 10'd0,  9'd0,  2'd0, 10'd640,10'd640,3'b000,1'b0,1'b0};
        vecs[17] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1, 10'd0,  9'd0,  2'd1, 10'd640,10'd640,3'b000,1'b0,1'b0};
        vecs[18] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1, 10'd0,  9'd0,  2'd1, 10'd638,10'd640,3'b001,1'b0,1'b0};

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0);
        step();

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst_n, vecs[i].st, vecs[i].sp, vecs[i].cl, vecs[i].tk, vecs[i].hc, vecs[i].vc);
            for (int r = 0; r < vecs[i].reps; r++) step();
            check(i, "state",  32'(bus.state),         32'(vecs[i].e_state));
            check(i, "left0",  32'(bus.obs_left[9:0]), 32'(vecs[i].e_left0));
            check(i, "right0", 32'(bus.obs_right[9:0]),32'(vecs[i].e_right0));
            check(i, "active", 32'(bus.obs_active),    32'(vecs[i].e_act));
            if (vecs[i].chk_pix)
                check(i, "pixel_on", 32'(bus.pixel_on), 32'(vecs[i].e_pix));
            if (i == 0) begin
                check(i, "score_rst",  32'(bus.score_pulse),    32'd0);
                check(i, "gap_top0",   32'(bus.gap_top[8:0]),   32'd40);
                check(i, "gap_bot0",   32'(bus.gap_bot[8:0]),   32'd160);
                check(i, "left2",      32'(bus.obs_left[29:20]),32'd640);
            end
        end

        // Fresh reset so the LFSR restarts from the seed, then run to channel 0's respawn.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0);
        step(); step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0);
        step();
        stray = 0;
        seen  = 0;
        for (int n = 1; n <= 340; n++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 9'd0);
            step();
            if (bus.score_pulse) begin
                if (n == 260) seen++;
                else stray++;
            end
        end
        check(100, "score_at_260",   32'(seen),  32'd1);
        check(100, "score_stray",    32'(stray), 32'd0);

        lfsr_m = 16'hACE1;
        for (int n = 0; n < 340; n++) lfsr_m = lfsr_step(lfsr_m);
        exp_gt = 9'd40 + {1'b0, lfsr_m[7:0]};
        check(101, "resp_left0",  32'(bus.obs_left[9:0]),    32'd640);
        check(101, "resp_right0", 32'(bus.obs_right[9:0]),   32'd640);
        check(101, "resp_active", 32'(bus.obs_active),       32'b110);
        check(101, "resp_gap_top0", 32'(bus.gap_top[8:0]),   32'(exp_gt));
        check(101, "resp_gap_bot0", 32'(bus.gap_bot[8:0]),   32'(exp_gt + 9'd120));
        check(101, "gap_top1",    32'(bus.gap_top[17:9]),    32'd40);
        check(101, "left1",       32'(bus.obs_left[19:10]),  32'd200);
        check(101, "left2",       32'(bus.obs_left[29:20]),  32'd440);
        check(101, "right2",      32'(bus.obs_right[29:20]), 32'd480);

        // Channel 1 crosses the bird column on tick 380; channel 0's respawn must stay silent.
        stray = 0;
        seen  = 0;
        for (int n = 341; n <= 380; n++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 9'd0);
            step();
            if (bus.score_pulse) begin
                if (n == 380) seen++;
                else stray++;
            end
        end
        check(102, "score_at_380", 32'(seen),  32'd1);
        check(102, "score_stray2", 32'(stray), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0);
        step();
        check(102, "score_one_cycle", 32'(bus.score_pulse), 32'd0);
        check(102, "left0_380", 32'(bus.obs_left[9:0]), 32'd600);

        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 9'd0);
        step();
        check(103, "clr_state",    32'(bus.state),              32'd0);
        check(103, "clr_gap_top0", 32'(bus.gap_top[8:0]),       32'd40);
        check(103, "clr_left1",    32'(bus.obs_left[19:10]),    32'd640);
        check(103, "clr_active",   32'(bus.obs_active),         32'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
